// File: rtl/cnn_out_writer.sv
// cnn_out_writer: output write-back stage of the CNN accelerator.
//
// The last-layer pixel stream is buffered in a DEPTH-word FIFO and drained
// into the frame SRAM, one word per cycle, whenever the arbiter asserts
// grant. Writes start at a base address latched on start and wrap modulo
// 2^W_WORD. A sticky done flag rises with write number frame_size.
//
// Optional feature: define CNN_OUT_CHECKSUM_EN to build a 32-bit running
// sum of every written word. Without it, checksum is tied to 0.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   start                one-cycle pulse, begins a frame (ignored while busy)
//   base_addr            first SRAM word address (sampled on start)
//   frame_size           words per frame (sampled on start)
//   in_pixel, in_valid   input stream, no backpressure
//   grant                SRAM port available this cycle
//   sram_en, sram_we     registered write strobes (1-cycle pulses)
//   sram_addr, sram_wdata registered write address / data
//   busy                 frame in progress
//   done                 sticky frame complete
//   overflow             sticky, a word was dropped on a full FIFO
//   checksum             running sum of written words (see above)
module cnn_out_writer #(
  parameter int W_DATA       = 32,
  parameter int W_WORD       = 14,
  parameter int W_FRAME_SIZE = 25,
  parameter int DEPTH        = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    start,
  input  logic [W_WORD-1:0]       base_addr,
  input  logic [W_FRAME_SIZE-1:0] frame_size,
  input  logic [W_DATA-1:0]       in_pixel,
  input  logic                    in_valid,
  input  logic                    grant,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [W_WORD-1:0]       sram_addr,
  output logic [W_DATA-1:0]       sram_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [31:0]             checksum
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]             PTR_ONE = (PW+1)'(1);
  localparam logic [W_FRAME_SIZE-1:0] CNT_ONE = W_FRAME_SIZE'(1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                  state_q;
  logic [W_WORD-1:0]       base_q;
  logic [W_FRAME_SIZE-1:0] size_q;
  logic [W_FRAME_SIZE-1:0] in_cnt_q;
  logic [W_FRAME_SIZE-1:0] wr_cnt_q;
  logic [W_FRAME_SIZE-1:0] wr_cnt_d;
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]             wr_ptr_q;
  logic [PW:0]             rd_ptr_q;
  logic [W_DATA-1:0]       mem_q [DEPTH];
  logic                    sram_en_q;
  logic [W_WORD-1:0]       sram_addr_q;
  logic [W_DATA-1:0]       sram_wdata_q;
  logic                    done_q;
  logic                    overflow_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              run;
  logic              pop;
  logic              accept;
  logic              push;
  logic              last_wr;
  logic [W_DATA-1:0] head;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    run        = (state_q == S_RUN);
    head       = mem_q[rd_ptr_q[PW-1:0]];
    pop        = run && !fifo_empty && grant;
    // Words beyond frame_size are ignored outright; words inside the frame
    // either enter the FIFO or are dropped, but always advance in_cnt.
    accept     = run && in_valid && (in_cnt_q < size_q);
    // A full FIFO still takes a word when the head leaves at the same edge.
    push       = accept && (!fifo_full || pop);
    wr_cnt_d   = wr_cnt_q + CNT_ONE;
    last_wr    = pop && (wr_cnt_d == size_q);
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= in_pixel;
  end

`ifdef CNN_OUT_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      checksum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + 32'(head);
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  // Control FSM with registered SRAM interface.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      size_q       <= '0;
      in_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sram_en_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sram_en_q <= pop;
      if (pop) begin
        // Address wraps modulo 2^W_WORD by truncation.
        sram_addr_q  <= base_q + W_WORD'(wr_cnt_q);
        sram_wdata_q <= head;
        wr_cnt_q     <= wr_cnt_d;
        rd_ptr_q     <= rd_ptr_q + PTR_ONE;
      end
      if (push)            wr_ptr_q   <= wr_ptr_q + PTR_ONE;
      if (accept)          in_cnt_q   <= in_cnt_q + CNT_ONE;
      if (accept && !push) overflow_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            size_q     <= frame_size;
            in_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            // An empty frame completes immediately.
            if (frame_size != '0) begin
              state_q <= S_RUN;
              done_q  <= 1'b0;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (last_wr) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_en_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cnn_out_writer.sv
module tb_cnn_out_writer;

  logic        HCLK;
  logic        HRESETn;
  logic        start;
  logic [13:0] base_addr;
  logic [24:0] frame_size;
  logic [31:0] in_pixel;
  logic        in_valid;
  logic        grant;
  logic        sram_en;
  logic        sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [31:0] checksum;

  int checks;
  int failures;

  logic [13:0] wa[$];
  logic [31:0] wd[$];
  int first_wr_c;
  int last_wr_c;
  int done_c;
  int we_bad;

  cnn_out_writer dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start      (start),
    .base_addr  (base_addr),
    .frame_size (frame_size),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .grant      (grant),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .checksum   (checksum)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apply_reset();
    HRESETn = 1'b0; start = 1'b0; base_addr = '0; frame_size = '0;
    in_pixel = '0; in_valid = 1'b0; grant = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic do_start(input logic [13:0] b, input logic [24:0] n);
    start = 1'b1; base_addr = b; frame_size = n;
    tick();
    start = 1'b0;
  endtask

  // Drives ncyc cycles of stimulus and records every SRAM write seen.
  task automatic run(input int ncyc, input int nwords, input logic [31:0] p0,
                     input logic [31:0] step, input int goff);
    wa.delete(); wd.delete();
    first_wr_c = -1; last_wr_c = -1; done_c = -1; we_bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      in_valid = (c < nwords);
      in_pixel = p0 + step * 32'(c);
      grant    = (c >= goff);
      tick();
      if (sram_we !== sram_en) we_bad++;
      if (sram_en === 1'b1) begin
        wa.push_back(sram_addr);
        wd.push_back(sram_wdata);
        if (first_wr_c < 0) first_wr_c = c;
        last_wr_c = c;
      end
      if (done === 1'b1 && done_c < 0) done_c = c;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({sram_en, sram_we, busy, done, overflow} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=00000", {sram_en, sram_we, busy, done, overflow}); end
    checks++; if (sram_addr !== 14'h0 || sram_wdata !== 32'h0) begin
      failures++; $display("FAIL reset_bus got addr=%h data=%h want 0", sram_addr, sram_wdata); end
    checks++; if (checksum !== 32'h0) begin
      failures++; $display("FAIL reset_checksum got=%h want=0", checksum); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_sum;
    do_start(14'h100, 25'd4);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
    run(8, 4, 32'h11, 32'h11, 0);
    checks++; if (wa.size() != 4) begin failures++; $display("FAIL basic_count got=%0d want=4", wa.size()); end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      checks++; if (wa[i] !== 14'(14'h100 + i) || wd[i] !== 32'h11 * 32'(i + 1)) begin
        failures++; $display("FAIL basic_write%0d got=%h/%h want=%h/%h", i, wa[i], wd[i], 14'(14'h100 + i), 32'h11 * 32'(i + 1)); end
    end
    checks++; if (first_wr_c != 1) begin failures++; $display("FAIL basic_latency got=%0d want=1", first_wr_c); end
    checks++; if (done_c != 4 || last_wr_c != 4) begin
      failures++; $display("FAIL basic_done_edge got done=%0d last=%0d want 4/4", done_c, last_wr_c); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL basic_end got busy=%b done=%b want 0/1", busy, done); end
    checks++; if (we_bad != 0) begin failures++; $display("FAIL basic_we got=%0d want=0", we_bad); end
`ifdef CNN_OUT_CHECKSUM_EN
    exp_sum = 32'hAA;
`else
    exp_sum = 32'h0;
`endif
    checks++; if (checksum !== exp_sum) begin failures++; $display("FAIL basic_checksum got=%h want=%h", checksum, exp_sum); end
  endtask

  task automatic test_grant_stall();
    logic [31:0] exp_sum;
    exp_sum = 32'h0;
    do_start(14'h0, 25'd16);
    run(40, 16, 32'hA000_0000, 32'h1, 10);
    checks++; if (wa.size() != 16) begin failures++; $display("FAIL stall_count got=%0d want=16", wa.size()); end
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
`ifdef CNN_OUT_CHECKSUM_EN
      exp_sum = exp_sum + 32'hA000_0000 + 32'(i);
`endif
      checks++; if (wa[i] !== 14'(i) || wd[i] !== 32'hA000_0000 + 32'(i)) begin
        failures++; $display("FAIL stall_write%0d got=%h/%h want=%h/%h", i, wa[i], wd[i], 14'(i), 32'hA000_0000 + 32'(i)); end
    end
    checks++; if (first_wr_c != 10) begin failures++; $display("FAIL stall_first got=%0d want=10", first_wr_c); end
    checks++; if (overflow !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL stall_flags got ovf=%b done=%b busy=%b want 0/1/0", overflow, done, busy); end
    checks++; if (checksum !== exp_sum) begin failures++; $display("FAIL stall_checksum got=%h want=%h", checksum, exp_sum); end
  endtask

  task automatic test_overflow();
    do_start(14'h40, 25'd20);
    run(20, 20, 32'hB0, 32'h1, 20);
    checks++; if (overflow !== 1'b1 || wa.size() != 0) begin
      failures++; $display("FAIL ovf_flag got ovf=%b writes=%0d want 1/0", overflow, wa.size()); end
    run(30, 0, 32'h0, 32'h0, 0);
    checks++; if (wa.size() != 16) begin failures++; $display("FAIL ovf_count got=%0d want=16", wa.size()); end
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      checks++; if (wa[i] !== 14'(14'h40 + i) || wd[i] !== 32'hB0 + 32'(i)) begin
        failures++; $display("FAIL ovf_write%0d got=%h/%h want=%h/%h", i, wa[i], wd[i], 14'(14'h40 + i), 32'hB0 + 32'(i)); end
    end
    checks++; if (busy !== 1'b1 || done !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_stuck got busy=%b done=%b ovf=%b want 1/0/1", busy, done, overflow); end
    apply_reset();
    checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_recover got busy=%b ovf=%b want 0/0", busy, overflow); end
  endtask

  task automatic test_wrap();
    logic [13:0] exp_a [4];
    exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
    do_start(14'h3FFE, 25'd4);
    run(8, 4, 32'h1, 32'h100, 0);
    checks++; if (wa.size() != 4) begin failures++; $display("FAIL wrap_count got=%0d want=4", wa.size()); end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      checks++; if (wa[i] !== exp_a[i] || wd[i] !== 32'h1 + 32'h100 * 32'(i)) begin
        failures++; $display("FAIL wrap_write%0d got=%h/%h want=%h/%h", i, wa[i], wd[i], exp_a[i], 32'h1 + 32'h100 * 32'(i)); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b want=1", done); end
  endtask

  task automatic test_zero_and_restart();
    do_start(14'h77, 25'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || sram_en !== 1'b0) begin
      failures++; $display("FAIL zero_done got done=%b busy=%b en=%b want 1/0/0", done, busy, sram_en); end
    run(3, 2, 32'h9, 32'h1, 0);
    checks++; if (wa.size() != 0 || done !== 1'b1) begin
      failures++; $display("FAIL zero_idle got writes=%0d done=%b want 0/1", wa.size(), done); end
    do_start(14'h20, 25'd4);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL restart_clear got done=%b busy=%b want 0/1", done, busy); end
    do_start(14'h50, 25'd1);
    run(8, 4, 32'h5, 32'h5, 0);
    checks++; if (wa.size() != 4) begin failures++; $display("FAIL ignore_count got=%0d want=4", wa.size()); end
    checks++; if (wa.size() > 0 && (wa[0] !== 14'h20 || wd[0] !== 32'h5)) begin
      failures++; $display("FAIL ignore_first got=%h/%h want=0020/00000005", wa[0], wd[0]); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL ignore_done got done=%b busy=%b want 1/0", done, busy); end
  endtask

  task automatic test_reset_mid();
    int nwr;
    nwr = 0;
    do_start(14'h200, 25'd8);
    for (int c = 0; c < 20 && nwr < 2; c++) begin
      in_valid = (c < 8); in_pixel = 32'hD0 + 32'(c); grant = 1'b1;
      tick();
      if (sram_en === 1'b1) nwr++;
    end
    checks++; if (nwr != 2) begin failures++; $display("FAIL mid_prewrites got=%0d want=2", nwr); end
    #2 HRESETn = 1'b0;
    #1;
    checks++; if ({sram_en, sram_we, busy, done, overflow} !== 5'b0 || sram_addr !== 14'h0 ||
                  sram_wdata !== 32'h0 || checksum !== 32'h0) begin
      failures++; $display("FAIL mid_reset got en=%b busy=%b addr=%h data=%h sum=%h want all 0",
                           sram_en, busy, sram_addr, sram_wdata, checksum); end
    in_valid = 1'b0; grant = 1'b0;
    #2 HRESETn = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || sram_en !== 1'b0) begin
      failures++; $display("FAIL mid_noresume got busy=%b en=%b want 0/0", busy, sram_en); end
    do_start(14'h300, 25'd2);
    run(6, 2, 32'hC1, 32'h1, 0);
    checks++; if (wa.size() != 2 || wa[0] !== 14'h300 || wd[0] !== 32'hC1 ||
                  wa[1] !== 14'h301 || wd[1] !== 32'hC2) begin
      failures++; $display("FAIL mid_clean got n=%0d", wa.size()); end
    checks++; if (done !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL mid_done got done=%b ovf=%b want 1/0", done, overflow); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_grant_stall();
    test_overflow();
    test_wrap();
    test_zero_and_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
